// File: rtl/disp_scan.sv
// Multiplexed seven-segment scanner: double-buffered value, one digit per SCAN_DIV cycles.
// Optional leading-zero blanking is compiled in with `define DISP_SCAN_LZB_EN.
module disp_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    blank,
    output logic [3:0]              nibble,
    output logic                    digit_en,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic [VAL_W-1:0]      active_q, active_d;
    logic                  pending_q, pending_d;
    logic [3:0]            nibble_q, nibble_d;
    logic                  digit_en_q, digit_en_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic                  frame_done_q, frame_done_d;
    logic                  tick;
    logic                  wrap;

`ifdef DISP_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] keep;
    logic                  nz_acc;
`endif

    always_comb begin
        tick = (pre_q == PRE_LAST);
        wrap = tick && (idx_q == IDX_LAST);

        pre_d = tick ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end

        // A load on the wrap tick bypasses the shadow so it shows on the very next edge.
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load) begin
            shadow_d = value;
            if (wrap) begin
                active_d  = value;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        digit_sel_d  = NUM_DIGITS'(1) << idx_d;
        nibble_d     = active_d[{idx_d, 2'b00} +: 4];
        frame_done_d = wrap;

`ifdef DISP_SCAN_LZB_EN
        // keep[i] is set when any nibble from i upward is non-zero; digit 0 always lit.
        keep   = '0;
        nz_acc = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_acc  = nz_acc | (|active_d[4*i +: 4]);
            keep[i] = nz_acc;
        end
        keep[0]    = 1'b1;
        digit_en_d = !blank && keep[idx_d];
`else
        digit_en_d = !blank;
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            nibble_q     <= 4'h0;
            digit_en_q   <= 1'b0;
            digit_sel_q  <= NUM_DIGITS'(1);
            frame_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            nibble_q     <= nibble_d;
            digit_en_q   <= digit_en_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign nibble     = nibble_q;
    assign digit_en   = digit_en_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with NUM_DIGITS=4, SCAN_DIV=4 (16-cycle frames).
module tb_disp_scan;

    localparam int ND = 4;
    localparam int SD = 4;
`ifdef DISP_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        n_rst;
    logic [15:0] value;
    logic        load;
    logic        blank;
    logic [3:0]  nibble;
    logic        digit_en;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int errors;
    int checks;
    int cyc;

    disp_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .value      (value),
        .load       (load),
        .blank      (blank),
        .nibble     (nibble),
        .digit_en   (digit_en),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc counts rising edges since reset release; outputs after edge cyc show digit (cyc/4)%4.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int cur_digit();
        return (cyc / SD) % ND;
    endfunction

    function automatic logic [3:0] nib_of(input logic [15:0] v, input int d);
        logic [15:0] s;
        s = v >> (4 * d);
        return s[3:0];
    endfunction

    function automatic logic en_of(input logic [15:0] v, input int d);
        logic lz;
        lz = (d == 0) || ((v >> (4 * d)) != 16'h0);
        return !LZB || lz;
    endfunction

    function automatic logic [3:0] sel_of(input int d);
        return 4'b0001 << d;
    endfunction

    task automatic test_reset();
        n_rst = 1'b0;
        value = 16'h0;
        load  = 1'b0;
        blank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (digit_sel !== 4'b0001) begin errors++; $display("FAIL reset_sel: got %b expected 0001", digit_sel); end
        checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble: got %h expected 0", nibble); end
        checks++; if (digit_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", digit_en); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
        n_rst = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_scan();
        logic exp_fd;
        for (int k = 0; k < 32; k++) begin
            step();
            exp_fd = (cyc % (ND * SD) == 0);
            checks++; if (digit_sel !== sel_of(cur_digit())) begin errors++; $display("FAIL scan_sel cyc=%0d: got %b expected %b", cyc, digit_sel, sel_of(cur_digit())); end
            checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL scan_nibble cyc=%0d: got %h expected 0", cyc, nibble); end
            checks++; if (frame_done !== exp_fd) begin errors++; $display("FAIL scan_fd cyc=%0d: got %b expected %b", cyc, frame_done, exp_fd); end
            checks++; if (digit_en !== en_of(16'h0, cur_digit())) begin errors++; $display("FAIL scan_en cyc=%0d: got %b expected %b", cyc, digit_en, en_of(16'h0, cur_digit())); end
        end
    endtask

    task automatic test_load();
        repeat (5) step();
        value = 16'h12AF;
        load  = 1'b1;
        step();
        load  = 1'b0;
        value = 16'h0;
        checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL load_hold cyc=%0d: got %h expected 0", cyc, nibble); end
        while (cyc % (ND * SD) != ND * SD - 1) begin
            step();
            checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL load_hold cyc=%0d: got %h expected 0", cyc, nibble); end
        end
        for (int k = 0; k < ND * SD; k++) begin
            step();
            checks++; if (nibble !== nib_of(16'h12AF, cur_digit())) begin errors++; $display("FAIL load_nibble cyc=%0d: got %h expected %h", cyc, nibble, nib_of(16'h12AF, cur_digit())); end
            checks++; if (digit_en !== 1'b1) begin errors++; $display("FAIL load_en cyc=%0d: got %b expected 1", cyc, digit_en); end
            checks++; if (digit_sel !== sel_of(cur_digit())) begin errors++; $display("FAIL load_sel cyc=%0d: got %b expected %b", cyc, digit_sel, sel_of(cur_digit())); end
        end
    endtask

    task automatic test_lzb();
        repeat (3) step();
        value = 16'h0030;
        load  = 1'b1;
        step();
        load  = 1'b0;
        while (cyc % (ND * SD) != ND * SD - 1) step();
        for (int k = 0; k < ND * SD; k++) begin
            step();
            checks++; if (nibble !== nib_of(16'h0030, cur_digit())) begin errors++; $display("FAIL lzb_nibble cyc=%0d: got %h expected %h", cyc, nibble, nib_of(16'h0030, cur_digit())); end
            checks++; if (digit_en !== en_of(16'h0030, cur_digit())) begin errors++; $display("FAIL lzb_en cyc=%0d: got %b expected %b", cyc, digit_en, en_of(16'h0030, cur_digit())); end
        end
    endtask

    task automatic test_back_to_back();
        repeat (2) step();
        value = 16'h1111;
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (3) step();
        value = 16'h2222;
        load  = 1'b1;
        step();
        load  = 1'b0;
        while (cyc % (ND * SD) != ND * SD - 1) step();
        for (int k = 0; k < ND * SD; k++) begin
            step();
            checks++; if (nibble !== 4'h2) begin errors++; $display("FAIL b2b_nibble cyc=%0d: got %h expected 2", cyc, nibble); end
        end
        // Load presented on the wrap tick itself.
        value = 16'h8765;
        load  = 1'b1;
        step();
        load  = 1'b0;
        value = 16'h0;
        checks++; if (nibble !== 4'h5) begin errors++; $display("FAIL wrapload_nibble: got %h expected 5", nibble); end
        checks++; if (digit_sel !== 4'b0001) begin errors++; $display("FAIL wrapload_sel: got %b expected 0001", digit_sel); end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL wrapload_fd: got %b expected 1", frame_done); end
        for (int k = 1; k < ND * SD; k++) begin
            step();
            checks++; if (nibble !== nib_of(16'h8765, cur_digit())) begin errors++; $display("FAIL wrapload_frame cyc=%0d: got %h expected %h", cyc, nibble, nib_of(16'h8765, cur_digit())); end
        end
    endtask

    task automatic test_blank();
        checks++; if (digit_en !== 1'b1) begin errors++; $display("FAIL blank_pre: got %b expected 1", digit_en); end
        blank = 1'b1;
        for (int k = 0; k < ND * SD; k++) begin
            step();
            checks++; if (digit_en !== 1'b0) begin errors++; $display("FAIL blank_en cyc=%0d: got %b expected 0", cyc, digit_en); end
            checks++; if (digit_sel !== sel_of(cur_digit())) begin errors++; $display("FAIL blank_sel cyc=%0d: got %b expected %b", cyc, digit_sel, sel_of(cur_digit())); end
            checks++; if (nibble !== nib_of(16'h8765, cur_digit())) begin errors++; $display("FAIL blank_nibble cyc=%0d: got %h expected %h", cyc, nibble, nib_of(16'h8765, cur_digit())); end
        end
        blank = 1'b0;
        step();
        checks++; if (digit_en !== 1'b1) begin errors++; $display("FAIL unblank_en: got %b expected 1", digit_en); end
    endtask

    task automatic test_reset_mid();
        repeat (8) step();
        value = 16'hABCD;
        load  = 1'b1;
        step();
        load  = 1'b0;
        value = 16'h0;
        checks++; if (digit_sel !== 4'b0100) begin errors++; $display("FAIL midrst_pre_sel: got %b expected 0100", digit_sel); end
        n_rst = 1'b0;
        #1;
        checks++; if (digit_sel !== 4'b0001) begin errors++; $display("FAIL midrst_sel: got %b expected 0001", digit_sel); end
        checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL midrst_nibble: got %h expected 0", nibble); end
        checks++; if (digit_en !== 1'b0) begin errors++; $display("FAIL midrst_en: got %b expected 0", digit_en); end
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 2 * ND * SD; k++) begin
            step();
            checks++; if (nibble !== 4'h0) begin errors++; $display("FAIL midrst_discard cyc=%0d: got %h expected 0", cyc, nibble); end
            checks++; if (digit_sel !== sel_of(cur_digit())) begin errors++; $display("FAIL midrst_scan cyc=%0d: got %b expected %b", cyc, digit_sel, sel_of(cur_digit())); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        test_reset();
        test_scan();
        test_load();
        test_lzb();
        test_back_to_back();
        test_blank();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
# disp_scan

Multiplexed display scanner that sits directly upstream of the seven-segment decoder. It holds a multi-digit hex value, time-multiplexes one digit at a time onto a 4-bit nibble bus plus enable (the decoder's `in`/`enable`), and drives a one-hot digit-select bus for the common-cathode/anode drivers. Loads are double-buffered and applied only at frame boundaries, so the display never tears.

## Interface
- `NUM_DIGITS`, default 4: digits scanned; legal range 2..8.
- `SCAN_DIV`, default 1024: clock cycles each digit is shown; legal range 2..65536.

- `clk`  in  1: system clock; all state on rising edge.
- `n_rst`  in  1: reset, asynchronous, active-low.
- `value`  in  4*NUM_DIGITS: hex value to display; nibble i (`value[4i+3:4i]`) maps to digit i; digit 0 is least significant.
- `load`  in  1: capture `value` into the shadow register this cycle.
- `blank`  in  1: when high, forces `digit_en` low; scanning continues.
- `nibble`  out  4: hex nibble of the currently selected digit; feeds the decoder `in`.
- `digit_en`  out  1: display enable for the current digit; feeds the decoder `enable`.
- `digit_sel`  out  NUM_DIGITS: one-hot, bit i high while digit i is shown.
- `frame_done`  out  1: single-cycle pulse on the cycle the scan wraps from digit NUM_DIGITS-1 to digit 0.

## Operation
- Registers:
  - prescaler `pre`, range 0..SCAN_DIV-1;
  - digit index `idx`, range 0..NUM_DIGITS-1;
  - `shadow` and `active`, each 4*NUM_DIGITS bits;
  - `pending` flag.
- Reset values:
  - `pre`=0, `idx`=0, `shadow`=0, `active`=0, `pending`=0.
  - Outputs: `nibble`=0, `digit_en`=0, `digit_sel`=1 (digit 0), `frame_done`=0.
- Prescaler:
  - Increments every cycle.
  - At `pre`==SCAN_DIV-1 (the tick), it returns to 0 and `idx` advances.
  - `idx` wraps from NUM_DIGITS-1 to 0.
- Frame wrap: the tick with `idx`==NUM_DIGITS-1.
  - `frame_done` is asserted on the following cycle, for exactly one cycle.
  - If `pending`=1: `active`<=`shadow`, `pending`<=0.
- Load:
  - `load`=1 on a non-wrap cycle: `shadow`<=`value`, `pending`<=1.
  - A later load before the wrap overwrites `shadow`. Last load wins.
- Simultaneous load and frame wrap: `value` goes directly into `active`, `shadow`<=`value`, `pending`<=0.
- Outputs are registered and computed from the next-state `idx` and `active`:
  - `digit_sel` = one-hot(`idx`).
  - `nibble` = `active[4*idx +: 4]`.
  - `digit_en` = !`blank` and the blanking rule below.
- `blank` affects only `digit_en`. `nibble` and `digit_sel` keep scanning.
- Reset mid-frame: asserting `n_rst`=0 immediately forces every register and output to its reset value and discards `pending`.

## Timing
- Each digit is shown for exactly SCAN_DIV cycles. One frame is NUM_DIGITS*SCAN_DIV cycles.
- `digit_sel`, `nibble` and `digit_en` change together on the clock edge where `pre` returns to 0. There are no intermediate glitch states.
- The first digit advance after reset release occurs SCAN_DIV edges later.
- Load-to-display latency:
  - Minimum 1 cycle (load on the wrap tick).
  - Maximum NUM_DIGITS*SCAN_DIV cycles.
- `blank` is registered, so `digit_en` responds one cycle after `blank` changes.
- `frame_done` occurs on the same edge where `digit_sel` returns to digit 0.

## Configuration
- Macro `DISP_SCAN_LZB_EN` controls leading-zero blanking.
- Defined:
  - Digit i (i≥1) has `digit_en`=0 when `active` nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked by this rule, so value 0 shows a single "0".
- Undefined: `digit_en` = !`blank` for every digit.
- `nibble` and `digit_sel` are identical in both builds.

## Test plan
Bench uses NUM_DIGITS=4 and SCAN_DIV=4.
- Reset, then release `n_rst`, no load: `digit_sel` steps 0001→0010→0100→1000→0001 every 4 cycles. `nibble`=0. `frame_done` pulses once per 16 cycles. `digit_en`=1 on digit 0; other digits 0 with LZB, 1 without.
- Load 16'h12AF mid-frame: `nibble` stays 0 until the next wrap. The following frame shows F, A, 2, 1 on digits 0..3, all `digit_en`=1.
- Load 16'h0030 with `DISP_SCAN_LZB_EN`: per frame `digit_en` = 1,1,0,0 on digits 0..3. Without the macro, `digit_en` = 1,1,1,1.
- Two loads in one frame (16'h1111 then 16'h2222): the next frame shows only 2. Load asserted exactly on the wrap tick: the value appears on digit 0 on the next edge.
- `blank`=1 for one full frame: `digit_en`=0 on all digits, starting one cycle after `blank` rises. `digit_sel` keeps rotating.
- Drop `n_rst` while on digit 2 with `pending`=1: outputs immediately reset (`digit_sel`=0001, `nibble`=0). The pending value is never displayed.
